// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO + frame scheduler feeding a UART transmit controller, one byte per frame.
// Latency: a byte pushed into an empty, idle feeder is presented (SBUF + En strobe) one edge later.
// Backpressure: pushes are dropped while Full; the next byte waits for the controller's Doneflg.
//
// Ports:
//   CLK, RSTn          clock, async active-low reset
//   Wr_en, Wr_data     push strobe and byte
//   Doneflg            frame-done pulse from the transmit controller
//   SBUF, En           byte under transmission, one-cycle start strobe
//   Full, Empty, Count FIFO occupancy (Count excludes the byte held in SBUF)
//   Busy               frame in flight or bytes pending
//   Overflow, Ovf_clr  sticky dropped-write flag and its clear
// Build option: define UART_TX_OVERFLOW_EN to synthesize the Overflow flag;
// otherwise Overflow is constant 0 and Ovf_clr is ignored.
module uart_tx_fifo_feeder #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  Wr_en,
  input  logic [7:0]            Wr_data,
  input  logic                  Doneflg,
  input  logic                  Ovf_clr,
  output logic [7:0]            SBUF,
  output logic                  En,
  output logic                  Full,
  output logic                  Empty,
  output logic [DEPTH_LOG2:0]   Count,
  output logic                  Busy,
  output logic                  Overflow
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [7:0]            r_sbuf;
  logic                  r_en;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;

  assign w_full  = (r_count == DEPTH_CNT);
  assign w_empty = (r_count == '0);
  // A push against a full FIFO is lost even if a pop frees a slot on the same edge.
  assign w_push  = Wr_en && !w_full;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        // Doneflg only matters here; a stray pulse in IDLE is ignored.
        if (Doneflg) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_sbuf   <= 8'h00;
      r_en     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_en    <= w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      // SBUF only changes on a pop, so it stays stable for the whole frame.
      if (w_pop) begin
        r_sbuf   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; contents are meaningless until written.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= Wr_data;
  end

`ifdef UART_TX_OVERFLOW_EN
  logic r_overflow;
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_overflow <= 1'b0;
    end else if (Wr_en && w_full) begin
      r_overflow <= 1'b1;     // set has priority over a simultaneous clear
    end else if (Ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end
  assign Overflow = r_overflow;
`else
  logic w_unused_ovf_clr;
  assign w_unused_ovf_clr = Ovf_clr;
  assign Overflow         = 1'b0;
`endif

  assign SBUF  = r_sbuf;
  assign En    = r_en;
  assign Full  = w_full;
  assign Empty = w_empty;
  assign Count = r_count;
  assign Busy  = (r_state == S_BUSY) || !w_empty;

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Directed bench for uart_tx_fifo_feeder: reset/idle, single-byte table,
// same-edge push/pop, burst ordering and gap, fill/drop/wrap, overflow flag, mid-frame reset.
module tb_uart_tx_fifo_feeder;

`ifdef UART_TX_OVERFLOW_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic       CLK;
  logic       RSTn;
  logic       Wr_en;
  logic [7:0] Wr_data;
  logic       Doneflg;
  logic       Ovf_clr;
  logic [7:0] SBUF;
  logic       En;
  logic       Full;
  logic       Empty;
  logic [4:0] Count;
  logic       Busy;
  logic       Overflow;

  uart_tx_fifo_feeder #(.DEPTH_LOG2(4)) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .Wr_en    (Wr_en),
    .Wr_data  (Wr_data),
    .Doneflg  (Doneflg),
    .Ovf_clr  (Ovf_clr),
    .SBUF     (SBUF),
    .En       (En),
    .Full     (Full),
    .Empty    (Empty),
    .Count    (Count),
    .Busy     (Busy),
    .Overflow (Overflow)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Bytes seen by the model controller at each start strobe.
  logic [7:0] got[$];
  always @(negedge CLK) begin
    if (RSTn && En) got.push_back(SBUF);
  end

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       done;
    logic       en;
    logic [7:0] sbuf;
    logic [4:0] cnt;
    logic       busy;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic wr, input logic [7:0] d, input logic done,
                              input logic en, input logic [7:0] sbuf,
                              input logic [4:0] cnt, input logic busy);
    vec_t v;
    v.wr = wr; v.d = d; v.done = done;
    v.en = en; v.sbuf = sbuf; v.cnt = cnt; v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Waits until the controller has seen n start strobes since base.
  task automatic wait_frames(input int base, input int n, input string nm);
    int guard;
    guard = 0;
    while ((got.size() - base) < n && guard < 60) begin
      tick();
      guard++;
    end
    if ((got.size() - base) < n) begin
      n_checks++;
      $display("FAIL %s: timeout waiting for frame %0d, got %0d", nm, n, got.size() - base);
    end
  endtask

  initial begin
    int base;
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    RSTn = 1'b0; Wr_en = 1'b0; Wr_data = 8'h00; Doneflg = 1'b0; Ovf_clr = 1'b0;

    //            wr    d      done  | en    sbuf   cnt   busy
    vecs[0]  = mk(1'b1, 8'hA5, 1'b0,  1'b0, 8'h00, 5'd1, 1'b1);
    vecs[1]  = mk(1'b0, 8'h00, 1'b0,  1'b1, 8'hA5, 5'd0, 1'b1);
    vecs[2]  = mk(1'b0, 8'h00, 1'b0,  1'b0, 8'hA5, 5'd0, 1'b1);
    vecs[3]  = mk(1'b0, 8'h00, 1'b0,  1'b0, 8'hA5, 5'd0, 1'b1);
    vecs[4]  = mk(1'b0, 8'h00, 1'b1,  1'b0, 8'hA5, 5'd0, 1'b0);
    vecs[5]  = mk(1'b0, 8'h00, 1'b0,  1'b0, 8'hA5, 5'd0, 1'b0);
    vecs[6]  = mk(1'b1, 8'h11, 1'b0,  1'b0, 8'hA5, 5'd1, 1'b1);
    vecs[7]  = mk(1'b1, 8'h22, 1'b0,  1'b1, 8'h11, 5'd1, 1'b1);
    vecs[8]  = mk(1'b1, 8'h33, 1'b0,  1'b0, 8'h11, 5'd2, 1'b1);
    vecs[9]  = mk(1'b1, 8'h44, 1'b0,  1'b0, 8'h11, 5'd3, 1'b1);
    vecs[10] = mk(1'b0, 8'h00, 1'b1,  1'b0, 8'h11, 5'd3, 1'b1);
    vecs[11] = mk(1'b1, 8'h55, 1'b0,  1'b1, 8'h22, 5'd3, 1'b1);
    vecs[12] = mk(1'b0, 8'h00, 1'b1,  1'b0, 8'h22, 5'd3, 1'b1);
    vecs[13] = mk(1'b0, 8'h00, 1'b0,  1'b1, 8'h33, 5'd2, 1'b1);
    vecs[14] = mk(1'b0, 8'h00, 1'b1,  1'b0, 8'h33, 5'd2, 1'b1);
    vecs[15] = mk(1'b0, 8'h00, 1'b0,  1'b1, 8'h44, 5'd1, 1'b1);
    vecs[16] = mk(1'b0, 8'h00, 1'b1,  1'b0, 8'h44, 5'd1, 1'b1);
    vecs[17] = mk(1'b0, 8'h00, 1'b0,  1'b1, 8'h55, 5'd0, 1'b1);
    vecs[18] = mk(1'b0, 8'h00, 1'b1,  1'b0, 8'h55, 5'd0, 1'b0);

    // Reset values while RSTn is held low.
    repeat (3) tick();
    chk("rst_sbuf", SBUF, 8'h00);
    chk("rst_en", En, 1'b0);
    chk("rst_empty", Empty, 1'b1);
    chk("rst_full", Full, 1'b0);
    chk("rst_count", Count, 5'd0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_ovf", Overflow, 1'b0);
    RSTn = 1'b1;

    // Idle with no traffic: {Empty,En,Busy,Count,SBUF}.
    for (int c = 0; c < 100; c++) begin
      tick();
      chk("idle", {Empty, En, Busy, Count, SBUF}, {1'b1, 1'b0, 1'b0, 5'd0, 8'h00});
    end

    // Single byte, then same-edge push/pop with new byte last out.
    for (int i = 0; i < 19; i++) begin
      Wr_en = vecs[i].wr; Wr_data = vecs[i].d; Doneflg = vecs[i].done;
      tick();
      chk($sformatf("v%0d_en", i), En, vecs[i].en);
      chk($sformatf("v%0d_sbuf", i), SBUF, vecs[i].sbuf);
      chk($sformatf("v%0d_count", i), Count, vecs[i].cnt);
      chk($sformatf("v%0d_empty", i), Empty, vecs[i].cnt == 5'd0);
      chk($sformatf("v%0d_full", i), Full, 1'b0);
      chk($sformatf("v%0d_busy", i), Busy, vecs[i].busy);
    end
    Wr_en = 1'b0; Doneflg = 1'b0;
    tick();

    // Burst 01..05 with the controller answering; next En two edges after Doneflg.
    base = got.size();
    for (int i = 0; i < 5; i++) begin
      Wr_en = 1'b1; Wr_data = 8'(i + 1);
      tick();
    end
    Wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_frames(base, i + 1, "burst_wait");
      tick(); tick();
      chk($sformatf("burst%0d_hold", i), SBUF, 8'(i + 1));
      Doneflg = 1'b1;
      tick();
      Doneflg = 1'b0;
      chk($sformatf("burst%0d_gap", i), En, 1'b0);
      tick();
      if (i < 4) begin
        chk($sformatf("burst%0d_next_en", i), En, 1'b1);
        chk($sformatf("burst%0d_next_sbuf", i), SBUF, 8'(i + 2));
      end else begin
        chk("burst_last_en", En, 1'b0);
        chk("burst_last_busy", Busy, 1'b0);
      end
    end
    tick();
    chk("burst_frames", got.size() - base, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("burst_order%0d", i), got[base + i], 8'(i + 1));

    // Fill with controller stalled: first byte goes to SBUF, 16 stored, 18th dropped.
    base = got.size();
    for (int i = 0; i < 18; i++) begin
      Wr_en = 1'b1; Wr_data = 8'hC0 + 8'(i);
      tick();
      if (i == 15) begin
        chk("fill15_count", Count, 5'd15);
        chk("fill15_full", Full, 1'b0);
      end
      if (i == 16) begin
        chk("fill16_count", Count, 5'd16);
        chk("fill16_full", Full, 1'b1);
        chk("fill16_ovf", Overflow, 1'b0);
      end
    end
    chk("drop_count", Count, 5'd16);
    chk("drop_ovf", Overflow, OVF_EN);
    chk("stall_sbuf", SBUF, 8'hC0);
    Wr_en = 1'b0; Ovf_clr = 1'b1;
    tick();
    chk("ovf_clear", Overflow, 1'b0);
    Wr_en = 1'b1; Wr_data = 8'hEE; Ovf_clr = 1'b1;
    tick();
    chk("ovf_set_wins", Overflow, OVF_EN);
    Wr_en = 1'b0; Ovf_clr = 1'b0;
    tick();
    chk("ovf_sticky", Overflow, OVF_EN);
    chk("drop2_count", Count, 5'd16);

    // Release the stall: 17 frames, wrapping both pointers.
    for (int i = 0; i < 17; i++) begin
      wait_frames(base, i + 1, "drain_wait");
      tick();
      Doneflg = 1'b1;
      tick();
      Doneflg = 1'b0;
    end
    tick(); tick();
    chk("drain_frames", got.size() - base, 17);
    for (int i = 0; i < 17; i++) chk($sformatf("drain_order%0d", i), got[base + i], 8'hC0 + 8'(i));
    chk("drain_count", Count, 5'd0);
    chk("drain_empty", Empty, 1'b1);
    chk("drain_busy", Busy, 1'b0);

    // Reset in the middle of a frame with one byte still queued.
    Wr_en = 1'b1; Wr_data = 8'h5A;
    tick();
    Wr_data = 8'h6B;
    tick();
    Wr_en = 1'b0;
    tick();
    chk("pre_rst_count", Count, 5'd1);
    RSTn = 1'b0;
    #1;
    chk("mid_rst_count", Count, 5'd0);
    chk("mid_rst_empty", Empty, 1'b1);
    chk("mid_rst_sbuf", SBUF, 8'h00);
    chk("mid_rst_busy", Busy, 1'b0);
    chk("mid_rst_ovf", Overflow, 1'b0);
    tick();
    RSTn = 1'b1;
    base = got.size();
    repeat (4) tick();
    chk("post_rst_no_frame", got.size() - base, 0);
    chk("post_rst_busy", Busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
